bpm_test_packet_gen: RTL and testbench

Parametrised BPM test-stream source in the Aurora user-clock domain. On each FA strobe it emits a burst of back-to-back test packets, one per BPM index, on an AXI-Stream TX link. Each packet is a header word followed by NUM_DATA_WORDS data words. It replaces the fixed single-packet test writer with these additions: configurable index range, selectable data patterns, backpressure-safe bursts, and overrun reporting.

---
 rtl/bpm_test_packet_gen.sv | 162 ++++++++++++++++
 tb/tb_bpm_test_packet_gen.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bpm_test_packet_gen.sv
// bpm_test_packet_gen: per-FA-strobe burst of BPM test packets on an AXI-Stream TX link.
// Optional build macro BPM_TEST_GEN_CHECKSUM_EN appends an XOR checksum word to each packet.
module bpm_test_packet_gen #(
    parameter int          NUM_DATA_WORDS  = 3,
    parameter int          INDEX_WIDTH     = 5,
    parameter int          INDEX_START_BIT = 10,
    parameter logic [15:0] HEADER_MAGIC    = 16'hA5BE
) (
    input  logic                   auroraUserClk,
    input  logic                   auroraResetN,
    input  logic                   auroraFAstrobe,
    input  logic                   auroraChannelUp,
    input  logic                   csrEnable,
    input  logic [INDEX_WIDTH-1:0] csrFirstIndex,
    input  logic [INDEX_WIDTH:0]   csrPacketCount,
    input  logic [1:0]             csrMode,
    output logic [31:0]            TDATA,
    output logic                   TVALID,
    output logic                   TLAST,
    input  logic                   TREADY,
    output logic [31:0]            faCycleCount,
    output logic                   overrunStrobe,
    output logic [15:0]            overrunCount,
    output logic                   busy
);
`ifdef BPM_TEST_GEN_CHECKSUM_EN
    localparam int LAST_K = NUM_DATA_WORDS;
`else
    localparam int LAST_K = NUM_DATA_WORDS - 1;
`endif
    localparam logic [3:0] LAST_K4 = 4'(LAST_K);
    localparam logic [3:0] NDW4    = 4'(NUM_DATA_WORDS);
    typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;
    state_t                 r_state;
    logic [INDEX_WIDTH-1:0] r_index;
    logic [INDEX_WIDTH:0]   r_remaining;
    logic [1:0]             r_mode;
    logic [3:0]             r_k;
    logic [31:0]            r_lfsr;
    logic [31:0]            r_csum;
    logic [31:0]            r_tdata;
    logic [31:0]            r_fa_count;
    logic                   r_tvalid;
    logic                   r_tlast;
    logic                   r_ovr_strobe;
    logic [15:0]            r_ovr_count;
    logic                   w_start;
    logic                   w_accept;
    logic                   w_last;
    logic                   w_is_data;
    logic                   w_more;
    logic [3:0]             w_next_k;
    logic [3:0]             w_k_load;
    logic [INDEX_WIDTH-1:0] w_next_index;
    logic [31:0]            w_lfsr_nxt;
    logic [31:0]            w_lfsr_use;
    logic [31:0]            w_data_word;
    logic [31:0]            w_word_load;

    function automatic logic [31:0] f_hdr(input logic [INDEX_WIDTH-1:0] idx);
        f_hdr = {HEADER_MAGIC, 16'(idx) << INDEX_START_BIT};
    endfunction

    function automatic logic [31:0] f_data(input logic [1:0] mode, input logic [INDEX_WIDTH-1:0] idx,
                                           input logic [3:0] k, input logic [31:0] fa, input logic [31:0] lfsr);
        f_data = (mode == 2'd0) ? fa :
                 (mode == 2'd1) ? {8'(idx), 8'(k), fa[15:0]} :
                 (mode == 2'd2) ? lfsr : 32'h0;
    endfunction

    assign w_start      = auroraFAstrobe && csrEnable && auroraChannelUp && (csrPacketCount != '0);
    assign w_accept     = r_tvalid && TREADY;
    assign w_last       = (r_k == LAST_K4);
    assign w_is_data    = (r_k < NDW4);
    assign w_more       = (r_remaining > {{INDEX_WIDTH{1'b0}}, 1'b1}) && auroraChannelUp;
    assign w_next_k     = r_k + 4'd1;
    assign w_k_load     = (r_state == HEADER) ? 4'd0 : w_next_k;
    assign w_next_index = r_index + 1'b1;
    // Galois step: shift right, fold the polynomial in when a one falls out of bit 0
    assign w_lfsr_nxt   = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? 32'h80200003 : 32'h0);
    // The LFSR only moves past a data word that was actually consumed in LFSR mode
    assign w_lfsr_use   = (r_state == DATA && r_mode == 2'd2 && w_is_data) ? w_lfsr_nxt : r_lfsr;
    assign w_data_word  = f_data(r_mode, r_index, w_k_load, r_fa_count, w_lfsr_use);
`ifdef BPM_TEST_GEN_CHECKSUM_EN
    assign w_word_load  = (r_state == DATA && w_next_k == NDW4) ? r_csum : w_data_word;
`else
    assign w_word_load  = w_data_word;
`endif

    // Burst sequencer: all stream outputs are loaded one cycle ahead so they come straight from flops
    always_ff @(posedge auroraUserClk) begin
        if (!auroraResetN) begin
            r_state      <= IDLE;
            r_index      <= '0;
            r_remaining  <= '0;
            r_mode       <= '0;
            r_k          <= '0;
            r_lfsr       <= 32'h1;
            r_csum       <= '0;
            r_tdata      <= '0;
            r_fa_count   <= '0;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
            r_ovr_strobe <= 1'b0;
            r_ovr_count  <= '0;
        end else begin
            r_ovr_strobe <= auroraFAstrobe && (r_state != IDLE);
            if (auroraFAstrobe && r_state != IDLE && r_ovr_count != 16'hFFFF)
                r_ovr_count <= r_ovr_count + 16'd1;
            if (w_accept)
                r_lfsr <= w_lfsr_use;
            case (r_state)
                IDLE: if (w_start) begin
                    r_index     <= csrFirstIndex;
                    r_remaining <= csrPacketCount;
                    r_mode      <= csrMode;
                    r_fa_count  <= r_fa_count + 32'd1;
                    r_tdata     <= f_hdr(csrFirstIndex);
                    r_csum      <= f_hdr(csrFirstIndex);
                    r_tvalid    <= 1'b1;
                    r_tlast     <= 1'b0;
                    r_state     <= HEADER;
                end
                HEADER: if (w_accept) begin
                    r_k     <= 4'd0;
                    r_tdata <= w_word_load;
                    r_csum  <= r_csum ^ w_word_load;
                    r_tlast <= (LAST_K4 == 4'd0);
                    r_state <= DATA;
                end
                DATA: if (w_accept) begin
                    if (!w_last) begin
                        r_k     <= w_next_k;
                        r_tdata <= w_word_load;
                        r_csum  <= r_csum ^ w_word_load;
                        r_tlast <= (w_next_k == LAST_K4);
                    end else if (w_more) begin
                        r_index     <= w_next_index;
                        r_remaining <= r_remaining - 1'b1;
                        r_tdata     <= f_hdr(w_next_index);
                        r_csum      <= f_hdr(w_next_index);
                        r_tlast     <= 1'b0;
                        r_state     <= HEADER;
                    end else begin
                        r_tvalid <= 1'b0;
                        r_tlast  <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign TDATA         = r_tdata;
    assign TVALID        = r_tvalid;
    assign TLAST         = r_tlast;
    assign faCycleCount  = r_fa_count;
    assign overrunStrobe = r_ovr_strobe;
    assign overrunCount  = r_ovr_count;
    assign busy          = (r_state != IDLE);
endmodule

// File: tb/tb_bpm_test_packet_gen.sv
// tb_bpm_test_packet_gen: scoreboard bench for bpm_test_packet_gen with a word-list reference model.
module tb_bpm_test_packet_gen;
    localparam int NDW = 3;
`ifdef BPM_TEST_GEN_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif
    localparam int W = NDW + 1 + (CS ? 1 : 0);

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        fa_strobe = 1'b0;
    logic        chan_up = 1'b1;
    logic        enable = 1'b1;
    logic [4:0]  first_idx = '0;
    logic [5:0]  pkt_count = '0;
    logic [1:0]  mode = '0;
    logic [31:0] tdata;
    logic        tvalid, tlast;
    logic        tready = 1'b1;
    logic [31:0] fa_count;
    logic        ovr_strobe;
    logic [15:0] ovr_count;
    logic        busy;

    bpm_test_packet_gen dut (
        .auroraUserClk(clk), .auroraResetN(resetn), .auroraFAstrobe(fa_strobe),
        .auroraChannelUp(chan_up), .csrEnable(enable), .csrFirstIndex(first_idx),
        .csrPacketCount(pkt_count), .csrMode(mode), .TDATA(tdata), .TVALID(tvalid),
        .TLAST(tlast), .TREADY(tready), .faCycleCount(fa_count), .overrunStrobe(ovr_strobe),
        .overrunCount(ovr_count), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [32:0] q[$];
    int          tests = 0, fails = 0;
    logic [31:0] m_fa = 0, m_lfsr = 32'h1;
    logic [15:0] m_ovr = 0;
    int          ovr_pulses = 0;
    int          rdy_pct = 100;
    bit          mon_en = 1'b1;
    logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [31:0] pd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // polynomial x^31+x^21+x+1 style right-shifting register, one step
    function automatic logic [31:0] galois(input logic [31:0] s);
        galois = (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
    endfunction

    // Expected word list for a burst: npk packets are actually transmitted
    task automatic model_burst(input int first, input int count, input int md, input int npk);
        logic [31:0] hdr, d, cs;
        int          idx;
        m_fa++;
        for (int p = 0; p < npk && p < count; p++) begin
            idx = (first + p) % 32;
            hdr = 32'hA5BE0000 | (32'(idx) << 10);
            cs  = hdr;
            q.push_back({1'b0, hdr});
            for (int k = 0; k < NDW; k++) begin
                case (md)
                    0: d = m_fa;
                    1: d = {8'(idx), 8'(k), m_fa[15:0]};
                    2: begin d = m_lfsr; m_lfsr = galois(m_lfsr); end
                    default: d = 32'h0;
                endcase
                cs ^= d;
                q.push_back({(k == NDW - 1) && !CS, d});
            end
            if (CS) q.push_back({1'b1, cs});
        end
    endtask

    // Monitor: pops the scoreboard on each accepted word and checks stall stability
    always @(negedge clk) begin
        if (mon_en) begin
            if (pv && !pr) begin
                chk("hold_valid", 32'(tvalid), 32'd1);
                chk("hold_data", tdata, pd);
                chk("hold_last", 32'(tlast), 32'(pl));
            end
            if (tvalid && tready) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got %h expected none at %0t", tdata, $time);
                end else begin
                    logic [32:0] e;
                    e = q.pop_front();
                    chk("word_data", tdata, e[31:0]);
                    chk("word_last", 32'(tlast), 32'(e[32]));
                end
            end
            pv <= tvalid; pr <= tready; pd <= tdata; pl <= tlast;
        end else
            pv <= 1'b0;
    end

    always @(negedge clk) if (ovr_strobe && resetn) ovr_pulses <= ovr_pulses + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1 tready = ($urandom_range(99) < rdy_pct);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic strobe(input int f, input int c, input int md);
        @(posedge clk);
        #1;
        first_idx = 5'(f); pkt_count = 6'(c); mode = 2'(md); fa_strobe = 1'b1;
        @(posedge clk);
        #1 fa_strobe = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while ((q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= budget) begin
            fails++;
            $display("FAIL %s_timeout: got %0d words pending expected 0", name, q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int o0, f, c, md;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("rst_tvalid", 32'(tvalid), 0);
        chk("rst_tlast", 32'(tlast), 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fa", fa_count, 0);
        chk("rst_ovr", 32'(ovr_count), 0);
        chk("rst_ovr_strobe", 32'(ovr_strobe), 0);
        // basic single packet, mode 0
        model_burst(0, 1, 0, 1);
        strobe(0, 1, 0);
        wait_done("basic", 200);
        chk("basic_fa", fa_count, m_fa);
        // strobes that fail the start condition
        enable = 1'b0; strobe(0, 1, 0);
        enable = 1'b1; strobe(0, 0, 0);
        chan_up = 1'b0; strobe(0, 1, 0);
        chan_up = 1'b1;
        repeat (5) @(negedge clk);
        chk("ignored_fa", fa_count, m_fa);
        chk("ignored_busy", 32'(busy), 0);
        // index wrap, mode 1
        model_burst(30, 4, 1, 4);
        strobe(30, 4, 1);
        wait_done("wrap", 200);
        // backpressure, LFSR mode, full 32-packet burst
        rdy_pct = 50;
        f = $urandom_range(31);
        model_burst(f, 32, 2, 32);
        strobe(f, 32, 2);
        wait_done("backpressure", 3000);
        rdy_pct = 100;
        // overrun: six extra strobes while the burst runs
        o0 = ovr_pulses;
        model_burst(5, 32, 0, 32);
        strobe(5, 32, 0);
        for (int i = 0; i < 6; i++) begin
            repeat (19) @(posedge clk);
            #1 fa_strobe = 1'b1;
            @(posedge clk);
            #1 fa_strobe = 1'b0;
            m_ovr++;
        end
        wait_done("overrun", 400);
        chk("ovr_pulses", 32'(ovr_pulses - o0), 6);
        chk("ovr_count", 32'(ovr_count), 32'(m_ovr));
        chk("ovr_fa", fa_count, m_fa);
        // channel drop during packet 2 of 4
        model_burst(3, 4, 1, 2);
        strobe(3, 4, 1);
        repeat (W + 1) @(posedge clk);
        #1 chan_up = 1'b0;
        wait_done("chan_drop", 200);
        repeat (10) @(negedge clk);
        chk("chan_drop_busy", 32'(busy), 0);
        chan_up = 1'b1;
        // randomized bursts
        rdy_pct = 70;
        for (int i = 0; i < 6; i++) begin
            f = $urandom_range(31); c = $urandom_range(1, 4); md = $urandom_range(3);
            model_burst(f, c, md, c);
            strobe(f, c, md);
            wait_done("random", 500);
        end
        rdy_pct = 100;
        // reset in the middle of a packet
        model_burst(0, 2, 2, 2);
        strobe(0, 2, 2);
        @(posedge clk);
        #1 mon_en = 1'b0; resetn = 1'b0;
        @(posedge clk);
        #1 q.delete();
        m_fa = 0; m_lfsr = 32'h1; m_ovr = 0;
        @(negedge clk);
        chk("mid_rst_tvalid", 32'(tvalid), 0);
        chk("mid_rst_tdata", tdata, 0);
        chk("mid_rst_fa", fa_count, 0);
        chk("mid_rst_ovr", 32'(ovr_count), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        resetn = 1'b1; mon_en = 1'b1;
        model_burst(7, 2, 2, 2);
        strobe(7, 2, 2);
        wait_done("post_reset", 200);
        chk("post_reset_fa", fa_count, m_fa);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
